// File: rtl/nor_phy_pkg.sv
`default_nettype none
// ============================================================================
// nor_phy_pkg
//   FSM state encoding and counter constants shared by the NOR bus PHY.
//   Rev 1.0
// ============================================================================
package nor_phy_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      RD_WAIT  = 3'd2,
      RD_DONE  = 3'd3,
      WR_PULSE = 3'd4,
      WR_HOLD  = 3'd5,
      TURN     = 3'd6
   } nor_phy_state_t;

   localparam int CNT_ONE = 1;

endpackage
`default_nettype wire

// File: rtl/nor_ry_sync.sv
`default_nettype none
// ============================================================================
// nor_ry_sync
//   Multi-flop synchroniser for the asynchronous RY/BY# pin; resets to busy.
//   Rev 1.0
// ============================================================================
module nor_ry_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic sync_o
);

   logic [STAGES-1:0] sync_sr;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_sr <= '0;
      end else begin
         sync_sr <= {sync_sr[STAGES-2:0], async_i};
      end
   end

   assign sync_o = sync_sr[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/nor_bus_phy.sv
`default_nettype none
// ============================================================================
// nor_bus_phy
//   NOR parallel-bus PHY: single-beat requests to registered CE#/OE#/WE# strobes.
//   Rev 1.0
// ============================================================================
module nor_bus_phy
   import nor_phy_pkg::*;
#(
   parameter int ADDR_W  = 26,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 8,
   parameter int RY_SYNC = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   input  logic [CNT_W-1:0]  cfg_rd_wait_i,
   input  logic [CNT_W-1:0]  cfg_wr_pulse_i,
   input  logic [CNT_W-1:0]  cfg_turn_i,
   input  logic              cfg_wait_ry_i,
   output logic              ry_busy_o,
   output logic [ADDR_W-1:0] nor_addr_o,
   input  logic [DATA_W-1:0] nor_data_i,
   output logic [DATA_W-1:0] nor_data_o,
   output logic              nor_data_oe_o,
   output logic              nor_ce_o,
   output logic              nor_oe_o,
   output logic              nor_we_o,
   input  logic              nor_ry_i
);

   // Counter load value for a programmed cycle count; zero behaves like one.
   function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] cfg);
      return (cfg == '0) ? '0 : cfg - CNT_W'(CNT_ONE);
   endfunction

   nor_phy_state_t   state, state_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] rd_ld, wr_ld, turn_ld;
   logic             turn_zero;
   logic             acc_we;
   logic             ry_sync;
   logic             accept;
   logic             we_next;
   logic             ce_d, oe_d, we_d, doe_d, rsp_d;

   nor_ry_sync #(.STAGES(RY_SYNC)) u_ry_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (nor_ry_i),
      .sync_o  (ry_sync)
   );

   assign ry_busy_o   = ~ry_sync;
   assign req_ready_o = (state == IDLE) && !(cfg_wait_ry_i && ry_busy_o);
   assign accept      = req_valid_i && req_ready_o;
   assign we_next     = (state == IDLE) ? req_we_i : acc_we;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (accept) state_d = SETUP;
         SETUP:    state_d = acc_we ? WR_PULSE : RD_WAIT;
         RD_WAIT:  if (cnt == '0) state_d = RD_DONE;
         WR_PULSE: if (cnt == '0) state_d = WR_HOLD;
         RD_DONE,
         WR_HOLD:  state_d = turn_zero ? IDLE : TURN;
         TURN:     if (cnt == '0) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Strobe levels for the upcoming cycle; registered below so pins never glitch.
   always_comb begin
      ce_d  = 1'b1;
      oe_d  = 1'b1;
      we_d  = 1'b1;
      doe_d = 1'b0;
      rsp_d = 1'b0;
      case (state_d)
         SETUP: begin
            ce_d  = 1'b0;
            doe_d = we_next;
         end
         RD_WAIT: begin
            ce_d = 1'b0;
            oe_d = 1'b0;
         end
         RD_DONE: rsp_d = 1'b1;
         WR_PULSE: begin
            ce_d  = 1'b0;
            we_d  = 1'b0;
            doe_d = 1'b1;
         end
         WR_HOLD: begin
            ce_d  = 1'b0;
            doe_d = 1'b1;
            rsp_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt       <= '0;
         rd_ld     <= '0;
         wr_ld     <= '0;
         turn_ld   <= '0;
         turn_zero <= 1'b1;
         acc_we    <= 1'b0;
      end else begin
         if (accept) begin
            rd_ld     <= load_val(cfg_rd_wait_i);
            wr_ld     <= load_val(cfg_wr_pulse_i);
            turn_ld   <= load_val(cfg_turn_i);
            turn_zero <= (cfg_turn_i == '0);
            acc_we    <= req_we_i;
         end
         case (state)
            SETUP:            cnt <= acc_we ? wr_ld : rd_ld;
            RD_DONE, WR_HOLD: cnt <= turn_ld;
            RD_WAIT, WR_PULSE, TURN:
               if (cnt != '0) cnt <= cnt - CNT_W'(CNT_ONE);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         nor_ce_o      <= 1'b1;
         nor_oe_o      <= 1'b1;
         nor_we_o      <= 1'b1;
         nor_data_oe_o <= 1'b0;
         nor_addr_o    <= '0;
         nor_data_o    <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
      end else begin
         nor_ce_o      <= ce_d;
         nor_oe_o      <= oe_d;
         nor_we_o      <= we_d;
         nor_data_oe_o <= doe_d;
         rsp_valid_o   <= rsp_d;
         if (accept) begin
            nor_addr_o <= req_addr_i;
            nor_data_o <= req_wdata_i;
         end
         if (state == RD_WAIT && state_d == RD_DONE) begin
            rsp_rdata_o <= nor_data_i;
         end
      end
   end

endmodule
`default_nettype wire
